// File: rtl/alarm_pkg.sv
// alarm_pkg: shared widths and FSM state encoding for the alarm sequencer.
package alarm_pkg;
    localparam int TIME_W    = 7;
    localparam int ATTEMPT_W = 4;
    typedef enum logic [2:0] {IDLE, ARMED, RING, SNOOZE, DONE} state_t;
endpackage

// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if: user/equation-side signals of the alarm sequencer.
//   master (user + equation block): drives SetAlarm, AlarmIn, Correct, TurnOff.
//   slave  (alarm_sequencer): drives OngoingTimer, startEq2, Ringing, Attempts,
//          Dismissed, AlarmTime.
interface alarm_sequencer_if;
    import alarm_pkg::*;
    logic                 SetAlarm;
    logic [TIME_W-1:0]    AlarmIn;
    logic                 Correct;
    logic                 TurnOff;
    logic [TIME_W-1:0]    OngoingTimer;
    logic                 startEq2;
    logic                 Ringing;
    logic [ATTEMPT_W-1:0] Attempts;
    logic                 Dismissed;
    logic [TIME_W-1:0]    AlarmTime;
    modport master (
        output SetAlarm, AlarmIn, Correct, TurnOff,
        input  OngoingTimer, startEq2, Ringing, Attempts, Dismissed, AlarmTime
    );
    modport slave (
        input  SetAlarm, AlarmIn, Correct, TurnOff,
        output OngoingTimer, startEq2, Ringing, Attempts, Dismissed, AlarmTime
    );
endinterface

// File: rtl/unit_timer.sv
// unit_timer: prescaler producing a one-cycle tick every TICKS_PER_UNIT cycles
// and a time-of-day counter that wraps TIME_MAX -> 0 on each tick.
//   Clock, Reset : clock and synchronous active-high reset
//   o_tick       : one-cycle pulse at prescaler wrap
//   o_time       : registered time-of-day value
module unit_timer
    import alarm_pkg::*;
#(
    parameter int TICKS_PER_UNIT = 50_000_000,
    parameter int TIME_MAX       = 99
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic              o_tick,
    output logic [TIME_W-1:0] o_time
);
    localparam int PW = $clog2(TICKS_PER_UNIT);
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_UNIT - 1);
    localparam logic [TIME_W-1:0] TMAX = TIME_W'(TIME_MAX);
    logic [PW-1:0]     r_presc;
    logic [TIME_W-1:0] r_time;
    assign o_tick = r_presc == LAST;
    assign o_time = r_time;
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_presc <= '0;
            r_time  <= '0;
        end else begin
            r_presc <= o_tick ? '0 : r_presc + 1'b1;
            if (o_tick) r_time <= (r_time == TMAX) ? '0 : r_time + 1'b1;
        end
    end
endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: alarm FSM that rings until the equation block reports a
// correct answer, snoozing after MAX_ATTEMPTS wrong answers.
//   Clock, Reset : clock and synchronous active-high reset
//   bus          : alarm_sequencer_if slave (alarm programming, equation
//                  handshake, live time and status outputs)
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int TICKS_PER_UNIT = 50_000_000,
    parameter int TIME_MAX       = 99,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int SNOOZE_UNITS   = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    alarm_sequencer_if.slave bus
);
    localparam int SW = $clog2(SNOOZE_UNITS + 1);
    localparam logic [SW-1:0] SNZ = SW'(SNOOZE_UNITS);
    localparam logic [ATTEMPT_W:0] MAX_A = (ATTEMPT_W+1)'(MAX_ATTEMPTS);
    localparam logic [TIME_W-1:0] TMAX = TIME_W'(TIME_MAX);
    logic                 w_tick;
    logic [TIME_W-1:0]    w_time;
    state_t               r_state, w_state;
    logic [ATTEMPT_W-1:0] r_att, w_att, w_att_inc;
    logic [TIME_W-1:0]    r_alarm, w_alarm;
    logic [SW-1:0]        r_snz, w_snz;
    logic                 r_toff;
    logic                 w_edge, w_accept;
    unit_timer #(
        .TICKS_PER_UNIT(TICKS_PER_UNIT),
        .TIME_MAX      (TIME_MAX)
    ) u_timer (
        .Clock (Clock),
        .Reset (Reset),
        .o_tick(w_tick),
        .o_time(w_time)
    );
    assign w_edge    = bus.TurnOff & ~r_toff;
    assign w_accept  = bus.SetAlarm && (bus.AlarmIn <= TMAX) && (r_state == IDLE || r_state == ARMED);
    assign w_att_inc = (&r_att) ? r_att : r_att + 1'b1;
    always_comb begin
        w_state = r_state;
        w_att   = r_att;
        w_alarm = r_alarm;
        w_snz   = r_snz;
        // A valid SetAlarm only reaches here from IDLE/ARMED and beats a same-cycle match.
        if (w_accept) begin
            w_alarm = bus.AlarmIn;
            w_state = ARMED;
        end else begin
            case (r_state)
                ARMED: if (w_time == r_alarm) begin
                    w_state = RING;
                    w_att   = '0;
                end
                RING: if (w_edge) begin
                    if (bus.Correct) w_state = DONE;
                    else begin
                        w_att = w_att_inc;
                        if ({1'b0, r_att} + 1'b1 == MAX_A) begin
                            w_state = SNOOZE;
                            w_snz   = '0;
                        end
                    end
                end
                SNOOZE: if (w_tick) begin
                    w_snz = r_snz + 1'b1;
                    if (w_snz == SNZ) begin
                        w_state = RING;
                        w_att   = '0;
                    end
                end
                DONE: w_state = IDLE;
                default: ;
            endcase
        end
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
            r_att   <= '0;
            r_alarm <= '0;
            r_snz   <= '0;
            r_toff  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_att   <= w_att;
            r_alarm <= w_alarm;
            r_snz   <= w_snz;
            r_toff  <= bus.TurnOff;
        end
    end
    assign bus.OngoingTimer = w_time;
    assign bus.Ringing      = r_state == RING;
    assign bus.startEq2     = r_state == RING;
    assign bus.Dismissed    = r_state == DONE;
    assign bus.Attempts     = r_att;
    assign bus.AlarmTime    = r_alarm;
endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: directed self-checking bench for alarm_sequencer.
module tb_alarm_sequencer;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    alarm_sequencer_if bus ();

    alarm_sequencer #(
        .TICKS_PER_UNIT(4),
        .TIME_MAX      (9),
        .MAX_ATTEMPTS  (2),
        .SNOOZE_UNITS  (2)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    function automatic logic [6:0] exp_time();
        return 7'((cyc / 4) % 10);
    endfunction

    task automatic test_reset();
        bus.SetAlarm = 1'b0;
        bus.AlarmIn  = 7'd0;
        bus.Correct  = 1'b0;
        bus.TurnOff  = 1'b0;
        Reset = 1'b1;
        step();
        step();
        checks++; if (bus.OngoingTimer !== 7'd0) begin failures++; $display("FAIL reset_time got=%0d exp=0", bus.OngoingTimer); end
        checks++; if (bus.Ringing !== 1'b0) begin failures++; $display("FAIL reset_ringing got=%0b exp=0", bus.Ringing); end
        checks++; if (bus.startEq2 !== 1'b0) begin failures++; $display("FAIL reset_starteq2 got=%0b exp=0", bus.startEq2); end
        checks++; if (bus.Dismissed !== 1'b0) begin failures++; $display("FAIL reset_dismissed got=%0b exp=0", bus.Dismissed); end
        checks++; if (bus.Attempts !== 4'd0) begin failures++; $display("FAIL reset_attempts got=%0d exp=0", bus.Attempts); end
        checks++; if (bus.AlarmTime !== 7'd0) begin failures++; $display("FAIL reset_alarmtime got=%0d exp=0", bus.AlarmTime); end
        Reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_free_run();
        for (int n = 1; n <= 40; n++) begin
            step();
            checks++; if (bus.OngoingTimer !== exp_time()) begin failures++; $display("FAIL free_time cyc=%0d got=%0d exp=%0d", cyc, bus.OngoingTimer, exp_time()); end
            checks++; if ({bus.Ringing, bus.startEq2, bus.Dismissed, bus.Attempts, bus.AlarmTime} !== 14'd0) begin failures++; $display("FAIL free_flags cyc=%0d got=%0h exp=0", cyc, {bus.Ringing, bus.startEq2, bus.Dismissed, bus.Attempts, bus.AlarmTime}); end
            if (n == 39) begin
                checks++; if (bus.OngoingTimer !== 7'd9) begin failures++; $display("FAIL free_time9 got=%0d exp=9", bus.OngoingTimer); end
            end
        end
        checks++; if (bus.OngoingTimer !== 7'd0) begin failures++; $display("FAIL free_wrap got=%0d exp=0", bus.OngoingTimer); end
    endtask

    task automatic test_bad_alarm();
        bus.SetAlarm = 1'b1;
        bus.AlarmIn  = 7'd12;
        step();
        bus.SetAlarm = 1'b0;
        checks++; if (bus.AlarmTime !== 7'd0) begin failures++; $display("FAIL bad_alarm_time got=%0d exp=0", bus.AlarmTime); end
        checks++; if (bus.Ringing !== 1'b0) begin failures++; $display("FAIL bad_alarm_ring got=%0b exp=0", bus.Ringing); end
    endtask

    task automatic test_alarm_dismiss();
        bus.SetAlarm = 1'b1;
        bus.AlarmIn  = 7'd3;
        step();
        bus.SetAlarm = 1'b0;
        checks++; if (bus.AlarmTime !== 7'd3) begin failures++; $display("FAIL arm_time got=%0d exp=3", bus.AlarmTime); end
        run_to(52);
        checks++; if (bus.OngoingTimer !== 7'd3) begin failures++; $display("FAIL arm_now got=%0d exp=3", bus.OngoingTimer); end
        checks++; if (bus.Ringing !== 1'b0) begin failures++; $display("FAIL ring_early got=%0b exp=0", bus.Ringing); end
        step();
        checks++; if ({bus.Ringing, bus.startEq2} !== 2'b11) begin failures++; $display("FAIL ring_start got=%0b exp=11", {bus.Ringing, bus.startEq2}); end
        checks++; if (bus.Attempts !== 4'd0) begin failures++; $display("FAIL ring_attempts got=%0d exp=0", bus.Attempts); end
        bus.TurnOff = 1'b1;
        bus.Correct = 1'b1;
        step();
        bus.TurnOff = 1'b0;
        bus.Correct = 1'b0;
        checks++; if ({bus.Dismissed, bus.startEq2, bus.Ringing} !== 3'b100) begin failures++; $display("FAIL dismiss got=%0b exp=100", {bus.Dismissed, bus.startEq2, bus.Ringing}); end
        step();
        checks++; if ({bus.Dismissed, bus.Ringing} !== 2'b00) begin failures++; $display("FAIL dismiss_end got=%0b exp=00", {bus.Dismissed, bus.Ringing}); end
        while (cyc < 100) begin
            step();
            checks++; if ({bus.Ringing, bus.Dismissed} !== 2'b00) begin failures++; $display("FAIL no_rering cyc=%0d got=%0b exp=00", cyc, {bus.Ringing, bus.Dismissed}); end
        end
    endtask

    task automatic test_snooze();
        bus.SetAlarm = 1'b1;
        bus.AlarmIn  = 7'd7;
        step();
        bus.SetAlarm = 1'b0;
        run_to(113);
        checks++; if (bus.Ringing !== 1'b1) begin failures++; $display("FAIL snz_ring got=%0b exp=1", bus.Ringing); end
        bus.TurnOff = 1'b1;
        step();
        bus.TurnOff = 1'b0;
        checks++; if ({bus.Ringing, bus.Attempts} !== 5'b1_0001) begin failures++; $display("FAIL wrong1 got=%0h exp=11", {bus.Ringing, bus.Attempts}); end
        step();
        bus.Correct = 1'b1;
        step();
        bus.Correct = 1'b0;
        checks++; if ({bus.Ringing, bus.Dismissed} !== 2'b10) begin failures++; $display("FAIL correct_no_edge got=%0b exp=10", {bus.Ringing, bus.Dismissed}); end
        bus.SetAlarm = 1'b1;
        bus.AlarmIn  = 7'd5;
        step();
        bus.SetAlarm = 1'b0;
        checks++; if (bus.AlarmTime !== 7'd7) begin failures++; $display("FAIL set_in_ring got=%0d exp=7", bus.AlarmTime); end
        bus.TurnOff = 1'b1;
        step();
        bus.TurnOff = 1'b0;
        checks++; if ({bus.Ringing, bus.startEq2, bus.Attempts} !== 6'b00_0010) begin failures++; $display("FAIL snooze_enter got=%0h exp=2", {bus.Ringing, bus.startEq2, bus.Attempts}); end
        run_to(123);
        checks++; if ({bus.Ringing, bus.Attempts} !== 5'b0_0010) begin failures++; $display("FAIL snooze_hold got=%0h exp=2", {bus.Ringing, bus.Attempts}); end
        step();
        checks++; if ({bus.Ringing, bus.startEq2, bus.Attempts} !== 6'b11_0000) begin failures++; $display("FAIL snooze_exit got=%0h exp=30", {bus.Ringing, bus.startEq2, bus.Attempts}); end
        bus.TurnOff = 1'b1;
        bus.Correct = 1'b1;
        step();
        bus.TurnOff = 1'b0;
        bus.Correct = 1'b0;
        checks++; if (bus.Dismissed !== 1'b1) begin failures++; $display("FAIL snz_dismiss got=%0b exp=1", bus.Dismissed); end
        step();
    endtask

    task automatic test_priority();
        bus.SetAlarm = 1'b1;
        bus.AlarmIn  = 7'd4;
        step();
        bus.SetAlarm = 1'b0;
        run_to(136);
        checks++; if (bus.OngoingTimer !== 7'd4) begin failures++; $display("FAIL prio_time got=%0d exp=4", bus.OngoingTimer); end
        bus.SetAlarm = 1'b1;
        bus.AlarmIn  = 7'd7;
        step();
        bus.SetAlarm = 1'b0;
        checks++; if ({bus.Ringing, bus.AlarmTime} !== 8'h07) begin failures++; $display("FAIL prio_set got=%0h exp=7", {bus.Ringing, bus.AlarmTime}); end
        while (cyc < 148) begin
            step();
            checks++; if (bus.Ringing !== 1'b0) begin failures++; $display("FAIL prio_quiet cyc=%0d got=%0b exp=0", cyc, bus.Ringing); end
        end
        step();
        checks++; if (bus.Ringing !== 1'b1) begin failures++; $display("FAIL prio_ring got=%0b exp=1", bus.Ringing); end
    endtask

    task automatic test_reset_mid_ring();
        bus.TurnOff = 1'b1;
        step();
        checks++; if (bus.Attempts !== 4'd1) begin failures++; $display("FAIL mid_attempts got=%0d exp=1", bus.Attempts); end
        Reset = 1'b1;
        step();
        checks++; if ({bus.OngoingTimer, bus.Ringing, bus.startEq2, bus.Dismissed, bus.Attempts, bus.AlarmTime} !== 21'd0) begin failures++; $display("FAIL mid_reset got=%0h exp=0", {bus.OngoingTimer, bus.Ringing, bus.startEq2, bus.Dismissed, bus.Attempts, bus.AlarmTime}); end
        Reset = 1'b0;
        bus.TurnOff = 1'b0;
        cyc = 0;
        run_to(3);
        checks++; if (bus.OngoingTimer !== 7'd0) begin failures++; $display("FAIL post_reset_t3 got=%0d exp=0", bus.OngoingTimer); end
        step();
        checks++; if (bus.OngoingTimer !== 7'd1) begin failures++; $display("FAIL post_reset_t4 got=%0d exp=1", bus.OngoingTimer); end
        checks++; if (bus.Ringing !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%0b exp=0", bus.Ringing); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_bad_alarm();
        test_alarm_dismiss();
        test_snooze();
        test_priority();
        test_reset_mid_ring();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
